// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback path. The widths match
// the register file so both sides of the write port agree.
package rf_wb_arbiter_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;

    // r0 is hardwired to zero in the register file; writes to it are dropped.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Width of an index into n requesters (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Combinational round-robin arbiter. The request vector is doubled so that a
// plain upward priority scan starting at ptr wraps around naturally; the
// first hit inside the window [ptr, ptr+N) is the winner.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [2*N-1:0] dbl;

    // Priority scan over the doubled request vector, starting at ptr.
    always_comb begin
        dbl     = {req, req};
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int j = 0; j < 2 * N; j++) begin
            if (!any && (j >= int'(ptr)) && (j < int'(ptr) + N) && dbl[j]) begin
                any     = 1'b1;
                gnt_idx = (j >= N) ? IW'(j - N) : IW'(j);
            end
        end
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: shares the single register-file write port among
// NUM_REQ requesters with round-robin fairness, a one-cycle registered
// output stage, and a saturating contention counter.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_REQ    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rf_wen,
    output logic [ADDR_WIDTH-1:0]         rf_waddr,
    output logic [DATA_WIDTH-1:0]         rf_wdata,
    output logic [31:0]                   conflict_cnt
);

    localparam int IW = idx_width(NUM_REQ);

    logic [IW-1:0]         ptr;
    logic [IW-1:0]         gnt_idx;
    logic [NUM_REQ-1:0]    arb_req;
    logic [NUM_REQ-1:0]    gnt;
    logic                  any;
    logic                  grant_any;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  contention;

    // A stall simply hides all requests from the arbiter.
    always_comb begin
        arb_req = stall ? '0 : req_valid;
    end

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req     (arb_req),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // No handshake may complete while reset is held.
    always_comb begin
        grant_any = any & ~rst;
        req_ready = gnt & {NUM_REQ{~rst}};
    end

    // One-hot AND-OR mux of the granted requester's address and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = sel_addr | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = sel_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Contention: two or more requesters competing in a non-stalled cycle.
    always_comb begin
        contention = !stall && ($countones(req_valid) >= 2);
    end

    // Round-robin pointer: the slot after the last winner gets top priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Output stage: r0 writes are consumed but never reach the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= grant_any && (sel_addr != ADDR_WIDTH'(REG_ZERO));
            if (grant_any) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
            end
        end
    end

    // Saturating contention counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (contention && (conflict_cnt != 32'hFFFF_FFFF)) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end

endmodule
